// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: issues req/ack data-memory accesses with byte
// enables, formats load data, stalls the pipeline and flags faulted accesses.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic [31:0] lsu_rdata,
  output logic        lsu_stall,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         off_q;
  logic [2:0]         f3_q;

  logic               illegal_c, start_c, bad_c, fin_ok_c, fin_to_c;
  logic [3:0]         be_c;
  logic [31:0]        wdata_c, shifted_c, load_c;

  // Access legality: reserved codes, unsigned stores, misaligned H/W
  always_comb begin
    illegal_c = 1'b0;
    if (lsu_funct3[1:0] == 2'b11)                           illegal_c = 1'b1;
    if (lsu_funct3 == 3'b110)                               illegal_c = 1'b1;
    if (lsu_we && lsu_funct3[2])                            illegal_c = 1'b1;
    if (lsu_funct3[1:0] == 2'b01 && lsu_addr[0])            illegal_c = 1'b1;
    if (lsu_funct3[1:0] == 2'b10 && lsu_addr[1:0] != 2'b00) illegal_c = 1'b1;
  end

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = lsu_wdata;
    case (lsu_funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << lsu_addr[1:0];
        wdata_c = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << lsu_addr[1:0];
        wdata_c = {2{lsu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane-select then extend the returned word
  always_comb begin
    shifted_c = mem_rdata >> {off_q, 3'b000};
    load_c    = shifted_c;
    case (f3_q)
      3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b001:  load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b100:  load_c = {24'd0, shifted_c[7:0]};
      3'b101:  load_c = {16'd0, shifted_c[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    lsu_stall = 1'b0;
    start_c   = 1'b0;
    bad_c     = 1'b0;
    fin_ok_c  = 1'b0;
    fin_to_c  = 1'b0;
    case (state)
      IDLE: begin
        if (lsu_valid) begin
          lsu_stall = 1'b1;
          start_c   = 1'b1;
          if (illegal_c) begin
            bad_c   = 1'b1;
            state_n = DONE;
          end else begin
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        lsu_stall = 1'b1;
        if (mem_ack) begin
          fin_ok_c = 1'b1;
          state_n  = DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          fin_to_c = 1'b1;
          state_n  = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Never freeze the pipeline while reset is asserted
    if (rst) begin
      lsu_stall = 1'b0;
      start_c   = 1'b0;
      bad_c     = 1'b0;
      fin_ok_c  = 1'b0;
      fin_to_c  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lsu_rdata <= 32'd0;
      lsu_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
      cnt       <= '0;
      off_q     <= 2'd0;
      f3_q      <= 3'd0;
    end else begin
      lsu_err <= bad_c | fin_to_c;
      if (start_c) begin
        mem_req   <= ~illegal_c;
        mem_we    <= lsu_we;
        mem_addr  <= {lsu_addr[31:2], 2'b00};
        mem_wdata <= wdata_c;
        mem_be    <= be_c;
        off_q     <= lsu_addr[1:0];
        f3_q      <= lsu_funct3;
        cnt       <= '0;
      end
      if (state == BUSY) cnt <= cnt + CNT_W'(1);
      if (fin_ok_c || fin_to_c) mem_req <= 1'b0;
      if (fin_ok_c && !mem_we) lsu_rdata <= load_c;
      if (fin_to_c && !mem_we) lsu_rdata <= 32'd0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit (TIMEOUT=4): access table plus
// reset, stray-ack and mid-access reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        lsu_stall, lsu_err;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .lsu_we(lsu_we),
    .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rdata(lsu_rdata), .lsu_stall(lsu_stall), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;    // BUSY cycle carrying mem_ack; 0 = never
    logic [31:0] rd;
    int          e_stall;
    int          e_req;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [31:0] e_maddr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One access: drive, run until stall drops, report what was observed
  task automatic run(input vec_t v, output int stall_n, output int req_n,
                     output logic err, output logic [31:0] rdata,
                     output logic [31:0] maddr, output logic [3:0] mbe,
                     output logic [31:0] mwdata, output logic mwe,
                     output logic stable, output logic done);
    stall_n = 0; req_n = 0; err = 1'b0; rdata = 32'd0;
    maddr = 32'd0; mbe = 4'd0; mwdata = 32'd0; mwe = 1'b0;
    stable = 1'b1; done = 1'b0;
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = v.we; lsu_funct3 = v.f3;
    lsu_addr = v.addr; lsu_wdata = v.wdata; mem_rdata = v.rd; mem_ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mem_req) begin
        req_n++;
        if (req_n == 1) begin
          maddr = mem_addr; mbe = mem_be; mwdata = mem_wdata; mwe = mem_we;
        end else if (maddr !== mem_addr || mbe !== mem_be ||
                     mwdata !== mem_wdata || mwe !== mem_we) begin
          stable = 1'b0;
        end
        mem_ack = (req_n == v.ack_at);
      end
      if (!lsu_stall) begin
        err = lsu_err; rdata = lsu_rdata; done = 1'b1;
        break;
      end
      stall_n++;
      @(negedge clk);
      mem_ack = 1'b0;
    end
    lsu_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int          s_n, r_n;
    logic        e, mwe_o, stb, dn;
    logic [31:0] rd_o, ma, mw;
    logic [3:0]  mb;
    vec_t        v;

    //             we    f3      addr          wdata         ack rd            st req err   rdata         maddr         be       wdata
    tbl.push_back('{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h0,         2, 1, 1'b0, 32'h0000_0000, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF});
    tbl.push_back('{1'b0, 3'b000, 32'h0000_0103, 32'h0,         1, 32'h8011_2233, 2, 1, 1'b0, 32'hFFFF_FF80, 32'h0000_0100, 4'b1000, 32'h0});
    tbl.push_back('{1'b0, 3'b100, 32'h0000_0103, 32'h0,         1, 32'h8011_2233, 2, 1, 1'b0, 32'h0000_0080, 32'h0000_0100, 4'b1000, 32'h0});
    tbl.push_back('{1'b0, 3'b101, 32'h0000_0102, 32'h0,         1, 32'h8011_2233, 2, 1, 1'b0, 32'h0000_8011, 32'h0000_0100, 4'b1100, 32'h0});
    tbl.push_back('{1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 1, 32'h0,         2, 1, 1'b0, 32'h0000_8011, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD});
    tbl.push_back('{1'b0, 3'b010, 32'h0000_0101, 32'h0,         1, 32'h0,         1, 0, 1'b1, 32'h0000_8011, 32'h0,         4'b0000, 32'h0});
    tbl.push_back('{1'b0, 3'b001, 32'h0000_0102, 32'h0,         3, 32'h1234_8765, 4, 3, 1'b0, 32'h0000_1234, 32'h0000_0100, 4'b1100, 32'h0});
    tbl.push_back('{1'b0, 3'b000, 32'h0000_0101, 32'h0,         2, 32'h0000_FF00, 3, 2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0100, 4'b0010, 32'h0});
    tbl.push_back('{1'b1, 3'b000, 32'h0000_0101, 32'h1234_56A5, 1, 32'h0,         2, 1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0100, 4'b0010, 32'hA5A5_A5A5});
    tbl.push_back('{1'b0, 3'b011, 32'h0000_0000, 32'h0,         1, 32'h0,         1, 0, 1'b1, 32'hFFFF_FFFF, 32'h0,         4'b0000, 32'h0});
    tbl.push_back('{1'b1, 3'b100, 32'h0000_0000, 32'h0,         1, 32'h0,         1, 0, 1'b1, 32'hFFFF_FFFF, 32'h0,         4'b0000, 32'h0});
    tbl.push_back('{1'b1, 3'b001, 32'h0000_0103, 32'h0,         1, 32'h0,         1, 0, 1'b1, 32'hFFFF_FFFF, 32'h0,         4'b0000, 32'h0});
    tbl.push_back('{1'b0, 3'b110, 32'h0000_0000, 32'h0,         1, 32'h0,         1, 0, 1'b1, 32'hFFFF_FFFF, 32'h0,         4'b0000, 32'h0});
    tbl.push_back('{1'b0, 3'b010, 32'h0000_0200, 32'h0,         0, 32'h5555_5555, 5, 4, 1'b1, 32'h0000_0000, 32'h0000_0200, 4'b1111, 32'h0});
    tbl.push_back('{1'b0, 3'b010, 32'h0000_0204, 32'h0,         4, 32'hCAFE_F00D, 5, 4, 1'b0, 32'hCAFE_F00D, 32'h0000_0204, 4'b1111, 32'h0});
    tbl.push_back('{1'b1, 3'b010, 32'h0000_0208, 32'h1111_2222, 0, 32'h0,         5, 4, 1'b1, 32'hCAFE_F00D, 32'h0000_0208, 4'b1111, 32'h1111_2222});
    tbl.push_back('{1'b0, 3'b001, 32'h0000_0000, 32'h0,         1, 32'h0000_8001, 2, 1, 1'b0, 32'hFFFF_8001, 32'h0000_0000, 4'b0011, 32'h0});
    tbl.push_back('{1'b0, 3'b101, 32'h0000_0000, 32'h0,         1, 32'h0001_FFFE, 2, 1, 1'b0, 32'h0000_FFFE, 32'h0000_0000, 4'b0011, 32'h0});
    tbl.push_back('{1'b0, 3'b010, 32'h0000_0000, 32'h0,         1, 32'h1234_5678, 2, 1, 1'b0, 32'h1234_5678, 32'h0000_0000, 4'b1111, 32'h0});

    rst = 1'b1; lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010;
    lsu_addr = 32'h0; lsu_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", 32'(lsu_stall), 32'd0);
    chk("reset_req", 32'(mem_req), 32'd0);
    chk("reset_err", 32'(lsu_err), 32'd0);
    chk("reset_rdata", lsu_rdata, 32'd0);
    chk("reset_mem", {mem_addr[31:6], mem_be, mem_we, 1'b0} | mem_wdata, 32'd0);
    lsu_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      v = tbl[i];
      run(v, s_n, r_n, e, rd_o, ma, mb, mw, mwe_o, stb, dn);
      chk($sformatf("v%0d_done", i), 32'(dn), 32'd1);
      chk($sformatf("v%0d_stall", i), 32'(s_n), 32'(v.e_stall));
      chk($sformatf("v%0d_req", i), 32'(r_n), 32'(v.e_req));
      chk($sformatf("v%0d_err", i), 32'(e), 32'(v.e_err));
      chk($sformatf("v%0d_rdata", i), rd_o, v.e_rdata);
      chk($sformatf("v%0d_err_clr", i), 32'(lsu_err), 32'd0);
      if (v.e_req > 0) begin
        chk($sformatf("v%0d_maddr", i), ma, v.e_maddr);
        chk($sformatf("v%0d_be", i), 32'(mb), 32'(v.e_be));
        chk($sformatf("v%0d_we", i), 32'(mwe_o), 32'(v.we));
        chk($sformatf("v%0d_stable", i), 32'(stb), 32'd1);
        if (v.we) chk($sformatf("v%0d_wdata", i), mw, v.e_wdata);
      end
    end

    // Stray ack while idle must change nothing
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("stray_ack_req", 32'(mem_req), 32'd0);
    chk("stray_ack_stall", 32'(lsu_stall), 32'd0);
    chk("stray_ack_rdata", lsu_rdata, 32'h1234_5678);
    @(negedge clk);
    chk("stray_ack_err", 32'(lsu_err), 32'd0);

    // Reset in the 2nd BUSY cycle abandons the access
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h0000_0300;
    @(negedge clk);
    chk("rst_mid_busy1", 32'(mem_req), 32'd1);
    @(negedge clk);
    chk("rst_mid_busy2", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_stall_in_rst", 32'(lsu_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0; lsu_valid = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_stall", 32'(lsu_stall), 32'd0);
    chk("rst_mid_rdata", lsu_rdata, 32'd0);
    v = '{1'b0, 3'b010, 32'h0, 32'h0, 1, 32'h0BAD_F00D, 2, 1, 1'b0,
          32'h0BAD_F00D, 32'h0, 4'b1111, 32'h0};
    run(v, s_n, r_n, e, rd_o, ma, mb, mw, mwe_o, stb, dn);
    chk("post_rst_done", 32'(dn), 32'd1);
    chk("post_rst_stall", 32'(s_n), 32'd2);
    chk("post_rst_err", 32'(e), 32'd0);
    chk("post_rst_rdata", rd_o, 32'h0BAD_F00D);
    chk("post_rst_be", 32'(mb), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the 5-stage RV32I pipeline. It takes the ALU-computed address, store data and width/sign code from the EX/MEM pipeline register. It drives a request/acknowledge data-memory port with byte enables, and produces the aligned, sign/zero-extended load result for the MEM/WB register. It holds the whole pipeline with a stall signal until each access completes, and it reports misaligned accesses, illegal width codes and memory timeouts.

## Interface
- TIMEOUT, default 16: maximum BUSY cycles waiting for mem_ack; legal range ≥1.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- lsu_valid  in  1  MEM stage holds a load/store; held stable while lsu_stall=1.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores use only 000/001/010.
- lsu_addr  in  32  byte address.
- lsu_wdata  in  32  store data (rs2).
- lsu_rdata  out  32  formatted load result; registered.
- lsu_stall  out  1  freeze IF..MEM stages; combinational.
- lsu_err  out  1  one-cycle error pulse; registered.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe, valid with mem_req.
- mem_addr  out  32  word address, bits [1:0] always 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  completion; mem_rdata valid in the same cycle.
- mem_rdata  in  32  read word.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If lsu_valid=1, lsu_stall=1 and the unit latches addr, we, funct3, be and the replicated wdata.
  - Legal access: next state BUSY.
  - Illegal access: next state DONE with err flag set; no request issued.
  - Illegal means H/HU/SH with addr[0]=1, W/SW with addr[1:0]≠00, any funct3 in {011,110,111}, or a store with funct3[2]=1.
- BUSY:
  - mem_req=1 and lsu_stall=1. mem_* are driven from the latched registers and are stable for the whole state.
  - Timeout counter increments each cycle.
  - mem_ack=1: capture formatted mem_rdata into lsu_rdata (loads only), then go to DONE.
  - Counter reaches TIMEOUT with no ack: go to DONE with err flag set, lsu_rdata←0 for loads.
  - Ack in the timeout cycle: ack wins, no error.
- DONE:
  - lsu_stall=0, so the pipeline advances at this edge.
  - lsu_err = err flag.
  - Next state is IDLE unconditionally. lsu_valid still high in DONE belongs to the completed instruction and is ignored.
- Byte enables:
  - B: 0001<<addr[1:0].
  - H: 0011<<addr[1:0].
  - W: 1111.
  - Loads drive the same mem_be.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load format: shift mem_rdata right by 8·addr[1:0], take the low 8 or 16 bits, then sign-extend (B/H) or zero-extend (BU/HU). W passes through.
- lsu_rdata holds its value until the next load completes. Stores and errored stores leave it unchanged.
- mem_ack while mem_req=0 is ignored.

## Timing
- Reset values: state IDLE, lsu_rdata 0, lsu_err 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0, counter 0.
- lsu_stall is 0 during reset.
- Legal access with ack in the k-th BUSY cycle (k≥1): stall high for 1+k cycles (IDLE plus BUSY), then DONE.
  - Minimum latency is 3 cycles per access.
  - Back-to-back accesses incur one IDLE cycle each.
- Illegal access: stall high for 1 cycle (IDLE), then DONE with lsu_err=1.
- Timeout: mem_req high for exactly TIMEOUT cycles, then DONE with lsu_err=1.
- rst asserted in any state: next cycle is IDLE and mem_req=0. The in-flight request is abandoned; the memory must tolerate a request withdrawn without ack.

## Test plan
- SW, addr 0x100, wdata 0xDEADBEEF, ack in first BUSY cycle → mem_addr 0x100, mem_be 1111, mem_we 1, mem_wdata 0xDEADBEEF; stall high 2 cycles; lsu_err 0.
- LB, addr 0x103, mem_rdata 0x80112233 → lsu_rdata 0xFFFFFF80. Repeat with LBU → 0x00000080. Repeat with LHU at 0x102 → 0x00008011.
- SH, addr 0x102, wdata 0x0000ABCD → mem_addr 0x100, mem_be 1100, mem_wdata 0xABCDABCD.
- LW, addr 0x101 → mem_req never asserted; stall 1 cycle; lsu_err pulse in the next cycle; lsu_rdata unchanged.
- TIMEOUT=4, load with mem_ack held 0 → mem_req high exactly 4 cycles, then lsu_err=1 and lsu_rdata=0. Repeat with ack in the 4th BUSY cycle → no error, data captured.
- rst pulsed in the 2nd BUSY cycle → next cycle mem_req=0, lsu_stall=0, lsu_rdata=0; a later LW at 0x0 with ack completes normally.
